// File: rtl/meas_lut_pkg.sv
// rtl/meas_lut_pkg.sv - shared types and defaults for the measurement-LUT distributor
//
// Purpose: per-core handshake state encoding and the default core count used by
// meas_lut_dist and meas_lut_dist_chan.
// Ports: none (package).
package meas_lut_pkg;

    localparam int N_CORES_DEF = 5;

    typedef enum logic [1:0] {
        DIST_IDLE = 2'd0,
        DIST_WAIT = 2'd1,
        DIST_DONE = 2'd2
    } dist_state_t;

endpackage

// File: rtl/meas_lut_dist_chan.sv
// rtl/meas_lut_dist_chan.sv - one core's slice of the measurement-LUT distributor
//
// Purpose: holds the most recent LUT bit for one core, tracks whether it has been
// consumed, answers the core's fproc req/ready handshake and counts results that
// were overwritten before being consumed.
// Optional feature: MEAS_LUT_DIST_TIMEOUT_EN adds a WAIT-state timeout that
// completes the handshake with err=1.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   lut_bit      this core's bit of the LUT word
//   lut_ready    1-cycle strobe qualifying lut_bit
//   req          core request level, held until ready
//   data         result bit, valid (else 0) while ready=1
//   ready        1-cycle completion strobe
//   err          timeout flag, qualifies ready
//   ovf_count    saturating count of unconsumed results overwritten
module meas_lut_dist_chan
    import meas_lut_pkg::*;
#(
    parameter int OVF_W     = 16,
    parameter int TIMEOUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lut_bit,
    input  logic             lut_ready,
    input  logic             req,
    output logic             data,
    output logic             ready,
    output logic             err,
    output logic [OVF_W-1:0] ovf_count
);

    localparam logic [OVF_W-1:0] OVF_MAX = {OVF_W{1'b1}};

    dist_state_t      state_q, state_d;
    logic             held_q, held_d;
    logic             fresh_q, fresh_d;
    logic             data_q, data_d;
    logic             err_q, err_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;
    logic             consume;
    logic             timeout_hit;

`ifdef MEAS_LUT_DIST_TIMEOUT_EN
    // Counter holds the number of WAIT cycles already completed; the cycle in
    // which it reads all-ones-minus-one is the (2**TIMEOUT_W-1)th WAIT cycle.
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = ~(TIMEOUT_W)'(1);
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d       = '0;
        timeout_hit = 1'b0;
        if (state_q == DIST_WAIT) begin
            timeout_hit = (tmo_q == TMO_LAST);
            tmo_d       = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state_d != DIST_WAIT) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        fresh_d = fresh_q;
        data_d  = data_q;
        err_d   = err_q;
        ovf_d   = ovf_q;
        consume = 1'b0;

        case (state_q)
            DIST_IDLE: begin
                data_d = 1'b0;
                err_d  = 1'b0;
                if (req) begin
                    if (fresh_q || lut_ready) begin
                        // A same-cycle strobe supersedes the held bit.
                        state_d = DIST_DONE;
                        data_d  = lut_ready ? lut_bit : held_q;
                        consume = 1'b1;
                    end else begin
                        state_d = DIST_WAIT;
                    end
                end
            end
            DIST_WAIT: begin
                if (!req) begin
                    state_d = DIST_IDLE;
                end else if (lut_ready) begin
                    // Checked ahead of the timeout so a late result still wins.
                    state_d = DIST_DONE;
                    data_d  = lut_bit;
                    consume = 1'b1;
                end else if (timeout_hit) begin
                    state_d = DIST_DONE;
                    data_d  = 1'b0;
                    err_d   = 1'b1;
                end
            end
            DIST_DONE: begin
                state_d = DIST_IDLE;
            end
            default: begin
                state_d = DIST_IDLE;
            end
        endcase

        if (lut_ready) begin
            held_d = lut_bit;
            if (consume) begin
                fresh_d = 1'b0;
            end else begin
                fresh_d = 1'b1;
                if (fresh_q && ovf_q != OVF_MAX) begin
                    ovf_d = ovf_q + 1'b1;
                end
            end
        end else if (consume) begin
            fresh_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DIST_IDLE;
            held_q  <= 1'b0;
            fresh_q <= 1'b0;
            data_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            fresh_q <= fresh_d;
            data_q  <= data_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready     = (state_q == DIST_DONE);
    assign data      = ready & data_q;
    assign err       = ready & err_q;
    assign ovf_count = ovf_q;

endmodule

// File: rtl/meas_lut_dist.sv
// rtl/meas_lut_dist.sv - measurement-LUT result distributor for N_CORES fproc ports
//
// Purpose: buffers each bit of the registered LUT word per core and answers every
// core's fproc request with a req/ready handshake, one independent channel per core.
// Optional feature: MEAS_LUT_DIST_TIMEOUT_EN enables per-core WAIT timeouts
// (core_err); without it core_err is tied 0.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   lut_out      LUT word, bit i for core i, sampled when lut_ready=1
//   lut_ready    1-cycle strobe qualifying lut_out
//   core_req     per-core request level
//   core_data    per-core result bit, 0 unless core_ready
//   core_ready   per-core 1-cycle completion strobe
//   core_err     per-core timeout flag qualifying core_ready
//   ovf_count    per-core overwrite counters, core i at [i*OVF_W +: OVF_W]
module meas_lut_dist
    import meas_lut_pkg::*;
#(
    parameter int N_CORES   = N_CORES_DEF,
    parameter int OVF_W     = 16,
    parameter int TIMEOUT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CORES-1:0]       lut_out,
    input  logic                     lut_ready,
    input  logic [N_CORES-1:0]       core_req,
    output logic [N_CORES-1:0]       core_data,
    output logic [N_CORES-1:0]       core_ready,
    output logic [N_CORES-1:0]       core_err,
    output logic [N_CORES*OVF_W-1:0] ovf_count
);

    for (genvar i = 0; i < N_CORES; i++) begin : g_chan
        meas_lut_dist_chan #(
            .OVF_W     (OVF_W),
            .TIMEOUT_W (TIMEOUT_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .lut_bit   (lut_out[i]),
            .lut_ready (lut_ready),
            .req       (core_req[i]),
            .data      (core_data[i]),
            .ready     (core_ready[i]),
            .err       (core_err[i]),
            .ovf_count (ovf_count[i*OVF_W +: OVF_W])
        );
    end

endmodule

// File: tb/tb_meas_lut_dist.sv
// tb/tb_meas_lut_dist.sv - self-checking bench for meas_lut_dist
module tb_meas_lut_dist;

    localparam int N  = 5;
    localparam int OW = 4;
`ifdef MEAS_LUT_DIST_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 16;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    lut_out;
    logic            lut_ready;
    logic [N-1:0]    core_req;
    logic [N-1:0]    core_data;
    logic [N-1:0]    core_ready;
    logic [N-1:0]    core_err;
    logic [N*OW-1:0] ovf_count;

    int checks   = 0;
    int failures = 0;

    // Expected {err,data} per core, pushed when stimulus is driven.
    logic [1:0] exp_q[N][$];
    logic [1:0] mon_e;

    meas_lut_dist #(
        .N_CORES   (N),
        .OVF_W     (OW),
        .TIMEOUT_W (TW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lut_out    (lut_out),
        .lut_ready  (lut_ready),
        .core_req   (core_req),
        .core_data  (core_data),
        .core_ready (core_ready),
        .core_err   (core_err),
        .ovf_count  (ovf_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (core_ready[i] === 1'b1) begin
                checks++;
                if (exp_q[i].size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ready core=%0d got err/data=%0b%0b required no response",
                             i, core_err[i], core_data[i]);
                end else begin
                    mon_e = exp_q[i].pop_front();
                    if ({core_err[i], core_data[i]} !== mon_e) begin
                        failures++;
                        $display("FAIL response core=%0d got err/data=%0b%0b required %02b",
                                 i, core_err[i], core_data[i], mon_e);
                    end
                end
            end else if (core_data[i] !== 1'b0 || core_err[i] !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL idle_outputs core=%0d got data=%0b err=%0b required 0 0",
                         i, core_data[i], core_err[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OW-1:0] get_ovf(int i);
        return ovf_count[i*OW +: OW];
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        lut_out   = '0;
        lut_ready = 1'b0;
        core_req  = '0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) exp_q[i].delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (core_ready !== '0 || core_data !== '0 || core_err !== '0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b data=%b err=%b required 0", core_ready, core_data, core_err);
        end
        checks++;
        if (ovf_count !== '0) begin
            failures++;
            $display("FAIL reset_ovf got %h required 0", ovf_count);
        end
    endtask

    task automatic test_fresh_hit();
        int seen;
        do_reset();
        lut_out   = 5'b10100;
        lut_ready = 1'b1;
        tick();
        lut_ready   = 1'b0;
        lut_out     = '0;
        core_req[2] = 1'b1;
        exp_q[2].push_back(2'b01);
        tick();
        checks++;
        if (core_ready !== 5'b00100) begin
            failures++;
            $display("FAIL fresh_latency got ready=%b required 00100", core_ready);
        end
        core_req[2] = 1'b0;
        tick();
        // Fresh was consumed, so a new request must wait.
        core_req[2] = 1'b1;
        seen = 0;
        repeat (3) begin
            tick();
            if (core_ready[2]) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL fresh_cleared got %0d responses required 0", seen);
        end
        core_req[2] = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_wait_then_lut();
        do_reset();
        core_req[4] = 1'b1;
        repeat (10) tick();
        checks++;
        if (core_ready !== '0) begin
            failures++;
            $display("FAIL wait_blocks got ready=%b required 0", core_ready);
        end
        lut_out   = 5'b10000;
        lut_ready = 1'b1;
        exp_q[4].push_back(2'b01);
        tick();
        lut_ready = 1'b0;
        checks++;
        if (core_ready !== 5'b10000) begin
            failures++;
            $display("FAIL wait_latency got ready=%b required 10000", core_ready);
        end
        core_req = '0;
        tick();
        tick();
    endtask

    task automatic test_same_cycle();
        do_reset();
        core_req[0] = 1'b1;
        lut_out     = 5'b00001;
        lut_ready   = 1'b1;
        exp_q[0].push_back(2'b01);
        tick();
        lut_ready = 1'b0;
        checks++;
        if (core_ready !== 5'b00001) begin
            failures++;
            $display("FAIL same_cycle_ready got ready=%b required 00001", core_ready);
        end
        core_req = '0;
        tick();
        checks++;
        if (get_ovf(0) !== '0) begin
            failures++;
            $display("FAIL same_cycle_ovf got %0d required 0", get_ovf(0));
        end
        // Consumed on the strobe edge: a follow-up request finds no fresh result.
        core_req[0] = 1'b1;
        repeat (3) tick();
        core_req = '0;
        tick();
        tick();
    endtask

    task automatic test_overflow();
        logic [N-1:0] v[3];
        do_reset();
        for (int k = 0; k < 3; k++) begin
            v[k]      = N'($urandom);
            lut_out   = v[k];
            lut_ready = 1'b1;
            tick();
            lut_ready = 1'b0;
            tick();
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (get_ovf(i) !== OW'(2)) begin
                failures++;
                $display("FAIL ovf_two core=%0d got %0d required 2", i, get_ovf(i));
            end
            exp_q[i].push_back({1'b0, v[2][i]});
        end
        core_req = '1;
        tick();
        checks++;
        if (core_ready !== '1 || core_data !== v[2]) begin
            failures++;
            $display("FAIL ovf_last_value got ready=%b data=%b required 11111 %b", core_ready, core_data, v[2]);
        end
        core_req = '0;
        tick();
        tick();
        // Saturation: 20 back-to-back strobes give 19 overwrites.
        do_reset();
        lut_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            lut_out = N'($urandom);
            tick();
        end
        lut_ready = 1'b0;
        tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (get_ovf(i) !== {OW{1'b1}}) begin
                failures++;
                $display("FAIL ovf_saturate core=%0d got %0d required %0d", i, get_ovf(i), {OW{1'b1}});
            end
        end
    endtask

    task automatic test_multi_core();
        do_reset();
        core_req = 5'b01010;
        repeat (3) tick();
        lut_out   = 5'b00010;
        lut_ready = 1'b1;
        exp_q[1].push_back(2'b01);
        exp_q[3].push_back(2'b00);
        tick();
        lut_ready = 1'b0;
        checks++;
        if (core_ready !== 5'b01010 || core_data !== 5'b00010) begin
            failures++;
            $display("FAIL multi_core got ready=%b data=%b required 01010 00010", core_ready, core_data);
        end
        core_req = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        core_req[2] = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        core_req = '0;
        tick();
        reset = 1'b0;
        seen  = 0;
        repeat (4) begin
            tick();
            if (core_ready !== '0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_mid got %0d response cycles required 0", seen);
        end
    endtask

`ifdef MEAS_LUT_DIST_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        do_reset();
        core_req[0] = 1'b1;
        exp_q[0].push_back(2'b10);
        n = 0;
        while (core_ready[0] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 16 || core_err[0] !== 1'b1 || core_data[0] !== 1'b0) begin
            failures++;
            $display("FAIL timeout got cycles=%0d err=%0b data=%0b required 16 1 0", n, core_err[0], core_data[0]);
        end
        core_req = '0;
        tick();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_fresh_hit();
        test_wait_then_lut();
        test_same_cycle();
        test_overflow();
        test_multi_core();
        test_reset_mid();
`ifdef MEAS_LUT_DIST_TIMEOUT_EN
        test_timeout();
`endif
        tick();
        for (int i = 0; i < N; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                failures++;
                $display("FAIL missing_ready core=%0d got %0d pending required 0", i, exp_q[i].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
